// File: rtl/vmem_lane_sequencer.sv
// Vector load/store lane sequencer: serialises a four-lane vector burst onto the
// single-ported data memory. The scalar core has priority, bounded by MAX_WAIT.
module vmem_lane_sequencer #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vreq_valid,
    output logic              vreq_ready,
    input  logic              vreq_store,
    input  logic [3:0]        vreq_lane_en,
    input  logic [ADDR_W-1:0] vreq_addr0,
    input  logic [ADDR_W-1:0] vreq_addr1,
    input  logic [ADDR_W-1:0] vreq_addr2,
    input  logic [ADDR_W-1:0] vreq_addr3,
    input  logic [DATA_W-1:0] vreq_wdata0,
    input  logic [DATA_W-1:0] vreq_wdata1,
    input  logic [DATA_W-1:0] vreq_wdata2,
    input  logic [DATA_W-1:0] vreq_wdata3,
    output logic [DATA_W-1:0] vload_data0,
    output logic [DATA_W-1:0] vload_data1,
    output logic [DATA_W-1:0] vload_data2,
    output logic [DATA_W-1:0] vload_data3,
    output logic              vdone,
    input  logic              core_req,
    input  logic [3:0]        core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_grant,
    output logic              core_stall,
    output logic [DATA_W-1:0] core_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t              r_state;
    logic                r_store;
    logic [3:0]          r_lane_en;
    logic [ADDR_W-1:0]   r_addr  [4];
    logic [DATA_W-1:0]   r_wdata [4];
    logic [DATA_W-1:0]   r_vload [4];
    logic [1:0]          r_ptr;
    logic [1:0]          r_cap_lane;
    logic                r_cap_pend;
    logic                r_vdone;
    logic [CNT_W-1:0]    r_starve;

    logic [ADDR_W-1:0]   w_addr_in  [4];
    logic [DATA_W-1:0]   w_wdata_in [4];
    logic [3:0]          w_higher;
    logic                w_last;
    logic                w_core_first;
    logic                w_vec_issue;

    function automatic logic [1:0] lowest_lane(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    assign w_addr_in[0]  = vreq_addr0;
    assign w_addr_in[1]  = vreq_addr1;
    assign w_addr_in[2]  = vreq_addr2;
    assign w_addr_in[3]  = vreq_addr3;
    assign w_wdata_in[0] = vreq_wdata0;
    assign w_wdata_in[1] = vreq_wdata1;
    assign w_wdata_in[2] = vreq_wdata2;
    assign w_wdata_in[3] = vreq_wdata3;
    assign vload_data0   = r_vload[0];
    assign vload_data1   = r_vload[1];
    assign vload_data2   = r_vload[2];
    assign vload_data3   = r_vload[3];

    // Enabled lanes strictly above the current pointer decide the next lane and burst end.
    assign w_higher     = r_lane_en & (4'b1110 << r_ptr);
    assign w_last       = (w_higher == 4'b0000);
    assign w_core_first = core_req && (int'(r_starve) < MAX_WAIT);
    assign w_vec_issue  = !rst && (r_state == ISSUE) && !w_core_first;

    assign vreq_ready = !rst && (r_state == IDLE);
    assign core_grant = !rst && core_req && !w_vec_issue;
    assign core_stall = core_req && !core_grant;
    assign core_rdata = mem_rdata;
    assign vdone      = r_vdone;

    always_comb begin
        mem_addr  = core_addr;
        mem_we    = 4'h0;
        mem_wdata = core_wdata;
        if (w_vec_issue) begin
            mem_addr  = r_addr[r_ptr];
            mem_we    = r_store ? 4'hF : 4'h0;
            mem_wdata = r_wdata[r_ptr];
        end else if (core_grant) begin
            mem_we = core_we;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_store    <= 1'b0;
            r_lane_en  <= 4'h0;
            r_ptr      <= 2'd0;
            r_cap_lane <= 2'd0;
            r_cap_pend <= 1'b0;
            r_vdone    <= 1'b0;
            r_starve   <= '0;
            for (int i = 0; i < 4; i++) begin
                r_vload[i] <= '0;
                r_addr[i]  <= '0;
                r_wdata[i] <= '0;
            end
        end else begin
            r_vdone    <= 1'b0;
            r_cap_pend <= 1'b0;
            // Registered-read memory: data for a lane issued last cycle is on mem_rdata now.
            if (r_cap_pend) r_vload[r_cap_lane] <= mem_rdata;
            case (r_state)
                IDLE: begin
                    if (vreq_valid) begin
                        r_store   <= vreq_store;
                        r_lane_en <= vreq_lane_en;
                        for (int i = 0; i < 4; i++) begin
                            r_addr[i]  <= w_addr_in[i];
                            r_wdata[i] <= w_wdata_in[i];
                            r_vload[i] <= '0;
                        end
                        if (vreq_lane_en == 4'h0) begin
                            r_state <= DONE;
                            r_vdone <= 1'b1;
                        end else begin
                            r_ptr   <= lowest_lane(vreq_lane_en);
                            r_state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (w_vec_issue) begin
                        r_starve <= '0;
                        if (!r_store) begin
                            r_cap_pend <= 1'b1;
                            r_cap_lane <= r_ptr;
                        end
                        r_ptr <= lowest_lane(w_higher);
                        if (w_last) begin
                            r_state <= r_store ? DONE : DRAIN;
                            r_vdone <= r_store;
                        end
                    end else begin
                        r_starve <= r_starve + CNT_W'(1);
                    end
                end
                DRAIN: begin
                    r_state <= DONE;
                    r_vdone <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vmem_lane_sequencer.sv
// Directed bench for vmem_lane_sequencer with a registered-read data memory behind it.
module tb_vmem_lane_sequencer;
    logic        clk;
    logic        rst;
    logic        vreq_valid;
    logic        vreq_ready;
    logic        vreq_store;
    logic [3:0]  vreq_lane_en;
    logic [11:0] va [4];
    logic [31:0] vw [4];
    logic [31:0] vl [4];
    logic        vdone;
    logic        core_req;
    logic [3:0]  core_we;
    logic [11:0] core_addr;
    logic [31:0] core_wdata;
    logic        core_grant;
    logic        core_stall;
    logic [31:0] core_rdata;
    logic [11:0] mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem  [0:4095];
    int          hits [0:4095];
    int          n_checks;
    int          n_fail;

    vmem_lane_sequencer #(.ADDR_W(12), .DATA_W(32), .MAX_WAIT(3)) dut (
        .clk(clk), .rst(rst),
        .vreq_valid(vreq_valid), .vreq_ready(vreq_ready), .vreq_store(vreq_store),
        .vreq_lane_en(vreq_lane_en),
        .vreq_addr0(va[0]), .vreq_addr1(va[1]), .vreq_addr2(va[2]), .vreq_addr3(va[3]),
        .vreq_wdata0(vw[0]), .vreq_wdata1(vw[1]), .vreq_wdata2(vw[2]), .vreq_wdata3(vw[3]),
        .vload_data0(vl[0]), .vload_data1(vl[1]), .vload_data2(vl[2]), .vload_data3(vl[3]),
        .vdone(vdone),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_grant(core_grant), .core_stall(core_stall), .core_rdata(core_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        if (|mem_we) hits[mem_addr] <= hits[mem_addr] + 1;
        mem_rdata <= mem[mem_addr];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    task automatic test_reset;
        rst = 1'b1; core_req = 1'b1; core_we = 4'hF; core_addr = 12'h000; core_wdata = 32'h0;
        tick; tick; settle;
        n_checks++; if (vreq_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %0h expected 0", vreq_ready); end
        n_checks++; if (core_grant !== 1'b0) begin n_fail++; $display("FAIL rst_grant: got %0h expected 0", core_grant); end
        n_checks++; if (mem_we !== 4'h0) begin n_fail++; $display("FAIL rst_mem_we: got %0h expected 0", mem_we); end
        n_checks++; if (vdone !== 1'b0) begin n_fail++; $display("FAIL rst_vdone: got %0h expected 0", vdone); end
        rst = 1'b0; core_req = 1'b0; core_we = 4'h0;
        tick; settle;
        n_checks++; if (vreq_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready: got %0h expected 1", vreq_ready); end
        n_checks++; if (vl[0] !== 32'h0) begin n_fail++; $display("FAIL post_rst_vload0: got %0h expected 0", vl[0]); end
        $display("reset: ready=%0h vdone=%0h", vreq_ready, vdone);
    endtask

    task automatic test_core_preload;
        for (int i = 0; i < 4; i++) begin
            core_req = 1'b1; core_we = 4'hF; core_addr = 12'h010 + 12'(i); core_wdata = 32'hA0 + 32'(i);
            settle;
            n_checks++; if (core_grant !== 1'b1) begin n_fail++; $display("FAIL pre_grant%0d: got %0h expected 1", i, core_grant); end
            n_checks++; if (mem_we !== 4'hF || mem_addr !== 12'h010 + 12'(i)) begin n_fail++; $display("FAIL pre_mem%0d: got we=%0h addr=%0h expected we=f addr=%0h", i, mem_we, mem_addr, 12'h010 + 12'(i)); end
            tick;
            $display("core write: addr=%0h data=%0h", core_addr, core_wdata);
        end
        core_req = 1'b0; core_we = 4'h0;
    endtask

    task automatic test_load_burst;
        vreq_valid = 1'b1; vreq_store = 1'b0; vreq_lane_en = 4'hF;
        for (int i = 0; i < 4; i++) va[i] = 12'h010 + 12'(i);
        settle;
        n_checks++; if (vreq_ready !== 1'b1) begin n_fail++; $display("FAIL ld_ready: got %0h expected 1", vreq_ready); end
        tick; vreq_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            settle;
            n_checks++; if (mem_addr !== 12'h010 + 12'(c - 1) || mem_we !== 4'h0) begin n_fail++; $display("FAIL ld_issue%0d: got addr=%0h we=%0h expected addr=%0h we=0", c, mem_addr, mem_we, 12'h010 + 12'(c - 1)); end
            n_checks++; if (vdone !== 1'b0) begin n_fail++; $display("FAIL ld_early_vdone%0d: got %0h expected 0", c, vdone); end
            tick;
        end
        settle;
        n_checks++; if (vdone !== 1'b0) begin n_fail++; $display("FAIL ld_drain_vdone: got %0h expected 0", vdone); end
        tick; settle;
        n_checks++; if (vdone !== 1'b1) begin n_fail++; $display("FAIL ld_vdone: got %0h expected 1", vdone); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (vl[i] !== 32'hA0 + 32'(i)) begin n_fail++; $display("FAIL ld_data%0d: got %0h expected %0h", i, vl[i], 32'hA0 + 32'(i)); end
        end
        tick; settle;
        n_checks++; if (vdone !== 1'b0 || vreq_ready !== 1'b1) begin n_fail++; $display("FAIL ld_after: got vdone=%0h ready=%0h expected vdone=0 ready=1", vdone, vreq_ready); end
        $display("load burst: vload=%0h %0h %0h %0h", vl[0], vl[1], vl[2], vl[3]);
    endtask

    task automatic test_empty_burst;
        vreq_valid = 1'b1; vreq_store = 1'b0; vreq_lane_en = 4'h0;
        settle; tick; vreq_valid = 1'b0; settle;
        n_checks++; if (vdone !== 1'b1) begin n_fail++; $display("FAIL empty_vdone: got %0h expected 1", vdone); end
        n_checks++; if (mem_we !== 4'h0) begin n_fail++; $display("FAIL empty_we: got %0h expected 0", mem_we); end
        n_checks++; if ((vl[0] | vl[1] | vl[2] | vl[3]) !== 32'h0) begin n_fail++; $display("FAIL empty_vload: got %0h %0h %0h %0h expected all 0", vl[0], vl[1], vl[2], vl[3]); end
        tick; settle;
        n_checks++; if (vdone !== 1'b0 || vreq_ready !== 1'b1) begin n_fail++; $display("FAIL empty_after: got vdone=%0h ready=%0h expected vdone=0 ready=1", vdone, vreq_ready); end
        $display("empty burst: vdone pulse seen, vload cleared");
    endtask

    task automatic test_store_sparse;
        int h [4];
        for (int i = 0; i < 4; i++) begin
            va[i] = 12'h100 + 12'(i); vw[i] = 32'h11 * 32'(i + 1); h[i] = hits[12'h100 + 12'(i)];
        end
        vreq_valid = 1'b1; vreq_store = 1'b1; vreq_lane_en = 4'b0101;
        settle; tick; vreq_valid = 1'b0; settle;
        n_checks++; if (mem_we !== 4'hF || mem_addr !== 12'h100 || mem_wdata !== 32'h11) begin n_fail++; $display("FAIL st_lane0: got we=%0h addr=%0h data=%0h expected we=f addr=100 data=11", mem_we, mem_addr, mem_wdata); end
        tick; settle;
        n_checks++; if (mem_we !== 4'hF || mem_addr !== 12'h102 || mem_wdata !== 32'h33) begin n_fail++; $display("FAIL st_lane2: got we=%0h addr=%0h data=%0h expected we=f addr=102 data=33", mem_we, mem_addr, mem_wdata); end
        tick; settle;
        n_checks++; if (vdone !== 1'b1 || mem_we !== 4'h0) begin n_fail++; $display("FAIL st_done: got vdone=%0h we=%0h expected vdone=1 we=0", vdone, mem_we); end
        tick;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (hits[12'h100 + 12'(i)] - h[i] !== ((i % 2 == 0) ? 1 : 0)) begin n_fail++; $display("FAIL st_hits%0d: got %0d writes expected %0d", i, hits[12'h100 + 12'(i)] - h[i], (i % 2 == 0) ? 1 : 0); end
        end
        $display("sparse store: lanes 0,2 written");
    endtask

    task automatic test_starvation;
        for (int i = 0; i < 4; i++) begin va[i] = 12'h110 + 12'(i); vw[i] = 32'hB0 + 32'(i); end
        core_req = 1'b1; core_we = 4'h0; core_addr = 12'h200;
        vreq_valid = 1'b1; vreq_store = 1'b1; vreq_lane_en = 4'hF;
        settle;
        n_checks++; if (vreq_ready !== 1'b1 || core_grant !== 1'b1) begin n_fail++; $display("FAIL sv_accept: got ready=%0h grant=%0h expected 1 1", vreq_ready, core_grant); end
        tick; vreq_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            settle;
            if (k % 4 == 3) begin
                n_checks++; if (core_grant !== 1'b0 || core_stall !== 1'b1 || mem_we !== 4'hF || mem_addr !== 12'h110 + 12'(k / 4) || mem_wdata !== 32'hB0 + 32'(k / 4)) begin
                    n_fail++; $display("FAIL sv_vec%0d: got grant=%0h stall=%0h we=%0h addr=%0h data=%0h expected 0 1 f %0h %0h", k, core_grant, core_stall, mem_we, mem_addr, mem_wdata, 12'h110 + 12'(k / 4), 32'hB0 + 32'(k / 4));
                end
            end else begin
                n_checks++; if (core_grant !== 1'b1 || core_stall !== 1'b0 || mem_we !== 4'h0 || mem_addr !== 12'h200) begin
                    n_fail++; $display("FAIL sv_core%0d: got grant=%0h stall=%0h we=%0h addr=%0h expected 1 0 0 200", k, core_grant, core_stall, mem_we, mem_addr);
                end
            end
            tick;
        end
        settle;
        n_checks++; if (vdone !== 1'b1 || core_grant !== 1'b1) begin n_fail++; $display("FAIL sv_done: got vdone=%0h grant=%0h expected 1 1", vdone, core_grant); end
        tick; core_req = 1'b0;
        $display("starvation store: 4 lanes in 16 issue cycles");
    endtask

    task automatic test_reset_midburst;
        int h [4];
        int seen;
        for (int i = 0; i < 4; i++) begin va[i] = 12'h120 + 12'(i); vw[i] = 32'hC0 + 32'(i); h[i] = hits[12'h120 + 12'(i)]; end
        vreq_valid = 1'b1; vreq_store = 1'b1; vreq_lane_en = 4'hF;
        settle; tick; vreq_valid = 1'b0;
        settle; tick;
        settle; tick;
        rst = 1'b1; settle;
        n_checks++; if (mem_we !== 4'h0) begin n_fail++; $display("FAIL rm_we: got %0h expected 0", mem_we); end
        tick; settle;
        n_checks++; if (vreq_ready !== 1'b0) begin n_fail++; $display("FAIL rm_ready_in_rst: got %0h expected 0", vreq_ready); end
        tick; rst = 1'b0; settle;
        n_checks++; if (vreq_ready !== 1'b1) begin n_fail++; $display("FAIL rm_ready: got %0h expected 1", vreq_ready); end
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (vdone === 1'b1 || mem_we !== 4'h0) seen++;
            tick; settle;
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL rm_quiet: got %0d cycles with vdone or write expected 0", seen); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (hits[12'h120 + 12'(i)] - h[i] !== ((i < 2) ? 1 : 0)) begin n_fail++; $display("FAIL rm_hits%0d: got %0d writes expected %0d", i, hits[12'h120 + 12'(i)] - h[i], (i < 2) ? 1 : 0); end
        end
        $display("reset mid-burst: lanes 0,1 written, burst aborted");
    endtask

    task automatic test_back_to_back;
        int h;
        int seen;
        h = hits[12'h130];
        va[0] = 12'h010; va[1] = 12'h011;
        vreq_valid = 1'b1; vreq_store = 1'b0; vreq_lane_en = 4'b0011;
        settle; tick;
        vreq_store = 1'b1; vreq_lane_en = 4'b0001; va[0] = 12'h130; vw[0] = 32'hDEAD;
        settle;
        n_checks++; if (vreq_ready !== 1'b0 || mem_addr !== 12'h010 || mem_we !== 4'h0) begin n_fail++; $display("FAIL bb_issue0: got ready=%0h addr=%0h we=%0h expected 0 10 0", vreq_ready, mem_addr, mem_we); end
        tick; vreq_valid = 1'b0; settle;
        n_checks++; if (mem_addr !== 12'h011 || mem_we !== 4'h0) begin n_fail++; $display("FAIL bb_issue1: got addr=%0h we=%0h expected 11 0", mem_addr, mem_we); end
        tick;
        core_req = 1'b1; core_we = 4'h0; core_addr = 12'h012; settle;
        n_checks++; if (core_grant !== 1'b1 || mem_addr !== 12'h012) begin n_fail++; $display("FAIL bb_drain_grant: got grant=%0h addr=%0h expected 1 12", core_grant, mem_addr); end
        tick; core_req = 1'b0; settle;
        n_checks++; if (core_rdata !== 32'hA2) begin n_fail++; $display("FAIL bb_core_rdata: got %0h expected a2", core_rdata); end
        n_checks++; if (vdone !== 1'b1) begin n_fail++; $display("FAIL bb_vdone: got %0h expected 1", vdone); end
        n_checks++; if (vl[0] !== 32'hA0 || vl[1] !== 32'hA1 || vl[2] !== 32'h0 || vl[3] !== 32'h0) begin n_fail++; $display("FAIL bb_vload: got %0h %0h %0h %0h expected a0 a1 0 0", vl[0], vl[1], vl[2], vl[3]); end
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            tick; settle;
            if (vdone === 1'b1 || mem_we !== 4'h0) seen++;
        end
        n_checks++; if (seen !== 0 || hits[12'h130] !== h) begin n_fail++; $display("FAIL bb_ignored: got %0d active cycles, %0d writes expected 0 0", seen, hits[12'h130] - h); end
        $display("back-to-back: second request ignored, core read in drain");
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        vreq_valid = 1'b0; vreq_store = 1'b0; vreq_lane_en = 4'h0;
        for (int i = 0; i < 4; i++) begin va[i] = 12'h0; vw[i] = 32'h0; end
        core_req = 1'b0; core_we = 4'h0; core_addr = 12'h0; core_wdata = 32'h0;
        rst = 1'b1;
        test_reset;
        test_core_preload;
        test_load_burst;
        test_empty_burst;
        test_store_sparse;
        test_starvation;
        test_reset_midburst;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
